game_round: RTL

Parametrised game-mode engine for the multi-game display board: counts player hits toward a target score and tracks remaining lives. Misses and round timeouts cost a life. The block drives the packed 5-bit-per-digit seven-segment word and raises victory/defeat flags. It replaces fixed single-target game modes and sits between the input debouncers (pulse-level hit/miss) and the display mux.

---
 rtl/game_pkg.sv | 36 +++
 rtl/game_round_if.sv | 27 ++
 rtl/round_timer.sv | 63 ++++++
 rtl/game_round.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the game-mode engine: digit codes, FSM states
// and the display-row assembly function.
package game_pkg;

    typedef logic [4:0] digit_t;

    localparam digit_t DIG_BLANK = 5'h1F;
    localparam digit_t DIG_DASH  = 5'h10;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        WIN,
        LOSE
    } game_state_t;

    function automatic digit_t to_digit(input logic [3:0] value);
        return {1'b0, value};
    endfunction

    // Code shown at position pos (0 = leftmost) of an n-digit row laid out as
    // first, fill ... fill, last.
    function automatic digit_t pack_digits(input int pos, input int n,
                                           input digit_t first, input digit_t fill,
                                           input digit_t last);
        digit_t code;
        code = fill;
        if (pos == 0) begin
            code = first;
        end else if (pos == n - 1) begin
            code = last;
        end
        return code;
    endfunction

endpackage

// File: rtl/game_round_if.sv
// Pulse inputs from the debouncers and registered display/status outputs of
// the game engine, bundled as one port.
interface game_round_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic                    enable;
    logic                    tick;
    logic                    hit;
    logic                    miss;
    logic [5*NUM_DIGITS-1:0] bits;
    logic [3:0]              score;
    logic [3:0]              lives_left;
    logic                    victory_flag;
    logic                    defeat_flag;

    modport master (
        output enable, tick, hit, miss,
        input  bits, score, lives_left, victory_flag, defeat_flag
    );

    modport slave (
        input  enable, tick, hit, miss,
        output bits, score, lives_left, victory_flag, defeat_flag
    );

endinterface

// File: rtl/round_timer.sv
// Round timeout counter and end-of-game blink divider, both driven by the
// shared time-base tick and restarted by a single clear.
module round_timer #(
    parameter int ROUND_TICKS = 8,
    parameter int BLINK_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic tick_i,
    output logic timeout_o,
    output logic blink_phase_o
);

    localparam int RW = (ROUND_TICKS > 1) ? $clog2(ROUND_TICKS) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUND_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [RW-1:0] round_cnt_q, round_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    assign timeout_o = tick_i && (round_cnt_q == ROUND_LAST);

    always_comb begin
        round_cnt_d   = round_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (clear_i) begin
            round_cnt_d   = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (tick_i) begin
            round_cnt_d = timeout_o ? '0 : round_cnt_q + 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // The phase is handed out as its next value so the display, which is
    // decoded from next-state values, flips on the same edge as the counter.
    assign blink_phase_o = blink_phase_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            round_cnt_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            round_cnt_q   <= round_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

endmodule

// File: rtl/game_round.sv
// Game-mode engine: counts hits toward TARGET, spends lives on misses and
// round timeouts, and drives the seven-segment digit word and end flags.
module game_round
    import game_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TARGET      = 7,
    parameter int LIVES       = 3,
    parameter int ROUND_TICKS = 8,
    parameter int BLINK_TICKS = 2
) (
    input  logic         clk,
    input  logic         reset,
    game_round_if.slave  bus
);

    localparam int         BITS_W       = 5 * NUM_DIGITS;
    localparam logic [3:0] TARGET_SCORE = 4'(TARGET);
    localparam logic [3:0] LIVES_INIT   = 4'(LIVES);

    game_state_t       state_q, state_d;
    logic [3:0]        score_q, score_d;
    logic [3:0]        lives_q, lives_d;
    logic [BITS_W-1:0] bits_q, bits_d;
    logic              victory_q, defeat_q;

    logic   timer_clear;
    logic   timeout;
    logic   blink_phase;
    digit_t first_dig, fill_dig, last_dig;

    round_timer #(
        .ROUND_TICKS (ROUND_TICKS),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_round_timer (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (timer_clear),
        .tick_i        (bus.tick),
        .timeout_o     (timeout),
        .blink_phase_o (blink_phase)
    );

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case leaves it unassigned and infers a latch.
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        unique case (state_q)
            IDLE: begin
                score_d = '0;
                lives_d = '0;
                if (bus.enable) begin
                    state_d = PLAY;
                    lives_d = LIVES_INIT;
                end
            end
            PLAY: begin
                // A hit masks any miss or timeout arriving in the same cycle.
                if (bus.hit) begin
                    if (score_q < TARGET_SCORE) begin
                        score_d = score_q + 4'd1;
                    end
                    if (score_d == TARGET_SCORE) begin
                        state_d = WIN;
                    end
                end else if (bus.miss || timeout) begin
                    if (lives_q != 4'd0) begin
                        lives_d = lives_q - 4'd1;
                    end
                    if (lives_d == 4'd0) begin
                        state_d = LOSE;
                    end
                end
            end
            default: begin
            end
        endcase
        if (!bus.enable) begin
            state_d = IDLE;
            score_d = '0;
            lives_d = '0;
        end
        // Any state change restarts both the round count and the blink phase.
        timer_clear = (state_d != state_q) || (state_q == PLAY && (bus.hit || bus.miss));
    end

    always_comb begin
        first_dig = DIG_BLANK;
        fill_dig  = DIG_DASH;
        last_dig  = DIG_BLANK;
        unique case (state_d)
            PLAY: begin
                first_dig = to_digit(score_d);
                last_dig  = to_digit(lives_d);
            end
            WIN: begin
                first_dig = blink_phase ? DIG_BLANK : to_digit(score_d);
                last_dig  = to_digit(lives_d);
            end
            LOSE: begin
                first_dig = blink_phase ? DIG_BLANK : DIG_DASH;
                fill_dig  = first_dig;
                last_dig  = first_dig;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        bits_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bits_d[5*(NUM_DIGITS-1-i) +: 5] = pack_digits(i, NUM_DIGITS, first_dig, fill_dig, last_dig);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            score_q   <= '0;
            lives_q   <= '0;
            bits_q    <= {DIG_BLANK, {(NUM_DIGITS-2){DIG_DASH}}, DIG_BLANK};
            victory_q <= 1'b0;
            defeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            bits_q    <= bits_d;
            victory_q <= (state_d == WIN);
            defeat_q  <= (state_d == LOSE);
        end
    end

    assign bus.bits         = bits_q;
    assign bus.score        = score_q;
    assign bus.lives_left   = lives_q;
    assign bus.victory_flag = victory_q;
    assign bus.defeat_flag  = defeat_q;

endmodule
